// File: rtl/if_stage_pkg.sv
// if_stage shared types: fetch-state encoding, IF->ID bundle, bus widths.
// Used by every file of the fetch stage (optional IF_PERF_EN lives in the top).
package if_stage_pkg;

   localparam int unsigned INST_ADDR_W = 32;
   localparam int unsigned INST_W      = 32;
   localparam logic [31:0] ZERO_WORD   = 32'h0;
   localparam logic [31:0] IF_RESET_PC = 32'h0000_0000;

   typedef enum logic [1:0] {
      IF_IDLE  = 2'd0,
      IF_RUN   = 2'd1,
      IF_DRAIN = 2'd2
   } if_state_e;

   typedef struct packed {
      logic [INST_ADDR_W-1:0] pc;
      logic [INST_W-1:0]      inst;
   } if_id_t;

   function automatic logic [31:0] word_align(input logic [31:0] a);
      return {a[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory request/grant/response bus.
// master = fetch stage, slave = memory.
interface if_stage_if;
   import if_stage_pkg::*;

   logic                   imem_req_o;
   logic [INST_ADDR_W-1:0] imem_addr_o;
   logic                   imem_gnt_i;
   logic                   imem_rvalid_i;
   logic [INST_W-1:0]      imem_rdata_i;

   modport master (
      output imem_req_o,
      output imem_addr_o,
      input  imem_gnt_i,
      input  imem_rvalid_i,
      input  imem_rdata_i
   );

   modport slave (
      input  imem_req_o,
      input  imem_addr_o,
      output imem_gnt_i,
      output imem_rvalid_i,
      output imem_rdata_i
   );

endinterface

// File: rtl/if_stage_fifo.sv
// if_fifo: small synchronous FIFO with flush, count and full/empty.
// DEPTH must be a power of two so the pointers wrap naturally.
module if_fifo #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush_i,
   input  logic                   push_i,
   input  logic [WIDTH-1:0]       data_i,
   input  logic                   pop_i,
   output logic [WIDTH-1:0]       data_o,
   output logic [$clog2(DEPTH):0] count_o,
   output logic                   full_o,
   output logic                   empty_o
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    rd_q, wr_q;
   logic [CW-1:0]    cnt_q;
   logic             push_ok, pop_ok;

   // a push into a full FIFO is only legal alongside a pop
   assign pop_ok  = pop_i & ~empty_o;
   assign push_ok = push_i & (~full_o | pop_ok);

   assign data_o  = mem_q[rd_q];
   assign count_o = cnt_q;
   assign full_o  = (cnt_q == CW'(DEPTH));
   assign empty_o = (cnt_q == '0);

   // pointer/count/storage update; flush drops everything at once
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (flush_i) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push_ok) begin
            mem_q[wr_q] <= data_i;
            wr_q        <= wr_q + AW'(1);
         end
         if (pop_ok) rd_q <= rd_q + AW'(1);
         cnt_q <= cnt_q + CW'(push_ok) - CW'(pop_ok);
      end
   end

endmodule

// File: rtl/if_stage.sv
// if_stage: PC owner, credit-limited fetch, prefetch FIFO to decode.
// `define IF_PERF_EN adds pop / dropped-response counters.
module if_stage
   import if_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = IF_RESET_PC,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst,
   if_stage_if.master        imem,
   input  logic              stall_i,
   input  logic              redirect_i,
   input  logic [31:0]       redirect_pc_i,
   output logic [31:0]       pc_o,
   output logic [31:0]       inst_o,
   output logic              inst_valid_o
`ifdef IF_PERF_EN
   ,
   output logic [31:0]       perf_fetched_o,
   output logic [31:0]       perf_dropped_o
`endif
);
   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

   if_state_e     state_q, state_d;
   logic [31:0]   pc_q, pc_d;
   logic [CW-1:0] outst_q, outst_d;
   logic [CW-1:0] drop_q, drop_d;
   logic [CW-1:0] pf_count, pend_count;
   logic [CW:0]   inflight;
   logic          req, fire, rv_ok, run_rv, pf_pop;
   logic          pf_empty, pf_full, pend_empty, pend_full;
   logic [31:0]   pend_pc;
   if_id_t        pf_in, pf_head;
   logic          unused_ok;

   // credit: never request more than the prefetch FIFO can absorb
   assign inflight = {1'b0, outst_q} + {1'b0, pf_count};
   assign req      = (state_q == IF_RUN) &&
                     (inflight < (CW+1)'(FIFO_DEPTH));
   assign fire     = req & imem.imem_gnt_i;
   // responses with nothing in flight are ignored
   assign rv_ok    = imem.imem_rvalid_i &
                     ((outst_q != '0) | (drop_q != '0));
   assign run_rv   = rv_ok & ~redirect_i & (state_q == IF_RUN);
   assign pf_pop   = ~pf_empty & ~stall_i & ~redirect_i;

   assign imem.imem_req_o  = req;
   assign imem.imem_addr_o = pc_q;

   assign pf_in   = '{pc: pend_pc, inst: imem.imem_rdata_i};
   assign inst_valid_o = ~pf_empty;
   assign pc_o    = pf_empty ? ZERO_WORD : pf_head.pc;
   assign inst_o  = pf_empty ? ZERO_WORD : pf_head.inst;

   assign unused_ok = &{1'b0, pf_full, pend_full,
                        pend_empty, pend_count};

   if_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_pend (
      .clk     (clk),
      .rst     (rst),
      .flush_i (redirect_i),
      .push_i  (fire),
      .data_i  (pc_q),
      .pop_i   (run_rv),
      .data_o  (pend_pc),
      .count_o (pend_count),
      .full_o  (pend_full),
      .empty_o (pend_empty)
   );

   if_fifo #(.WIDTH($bits(if_id_t)), .DEPTH(FIFO_DEPTH)) u_pf (
      .clk     (clk),
      .rst     (rst),
      .flush_i (redirect_i),
      .push_i  (run_rv),
      .data_i  (pf_in),
      .pop_i   (pf_pop),
      .data_o  (pf_head),
      .count_o (pf_count),
      .full_o  (pf_full),
      .empty_o (pf_empty)
   );

   // next state: redirect overrides, otherwise fetch or drain
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      outst_d = outst_q;
      drop_d  = drop_q;
      if (redirect_i) begin
         pc_d    = word_align(redirect_pc_i);
         outst_d = '0;
         drop_d  = outst_q + drop_q + CW'(fire) - CW'(rv_ok);
         state_d = (drop_d == '0) ? IF_RUN : IF_DRAIN;
      end else begin
         unique case (state_q)
            IF_IDLE: state_d = IF_RUN;
            IF_RUN: begin
               if (fire) pc_d = pc_q + 32'd4;
               outst_d = outst_q + CW'(fire) - CW'(run_rv);
            end
            IF_DRAIN: begin
               if (rv_ok) drop_d = drop_q - CW'(1);
               if (drop_d == '0) state_d = IF_RUN;
            end
            default: state_d = IF_IDLE;
         endcase
      end
   end

   // fetch control registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IF_IDLE;
         pc_q    <= RESET_PC;
         outst_q <= '0;
         drop_q  <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         outst_q <= outst_d;
         drop_q  <= drop_d;
      end
   end

`ifdef IF_PERF_EN
   logic drop_ev;
   assign drop_ev = rv_ok & (redirect_i | (state_q == IF_DRAIN));

   // free-running pop and discarded-response counters
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_fetched_o <= '0;
         perf_dropped_o <= '0;
      end else begin
         if (pf_pop)  perf_fetched_o <= perf_fetched_o + 32'd1;
         if (drop_ev) perf_dropped_o <= perf_dropped_o + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: scoreboard bench for if_stage with a latency-
// programmable instruction memory model.
module tb_if_stage;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } mreq_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        stall = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic [31:0] pc_o, inst_o;
   logic        inst_valid_o;
`ifdef IF_PERF_EN
   logic [31:0] perf_f, perf_d;
`endif

   if_stage_if imem ();

   if_stage #(.RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
      .clk           (clk),
      .rst           (rst),
      .imem          (imem),
      .stall_i       (stall),
      .redirect_i    (redirect),
      .redirect_pc_i (redirect_pc),
      .pc_o          (pc_o),
      .inst_o        (inst_o),
      .inst_valid_o  (inst_valid_o)
`ifdef IF_PERF_EN
      ,
      .perf_fetched_o(perf_f),
      .perf_dropped_o(perf_d)
`endif
   );

   always #5 clk = ~clk;

   int    lat = 1;
   int    grants_left = 0;
   int    granted = 0;
   int    mcyc = 0;
   mreq_t mq[$];

   exp_t  sb[$];
   int    npops = 0;
   int    ncyc = 0;
   int    pop_at[$];

   int    nchk = 0;
   int    nfail = 0;

   function automatic logic [31:0] memf(input logic [31:0] a);
      return a ^ 32'hA5C3_0F96;
   endfunction

   function automatic void check(input string nm,
                                 input logic [31:0] act,
                                 input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endfunction

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic push_exp(input logic [31:0] pc0, input int n);
      for (int i = 0; i < n; i++) begin
         exp_t e;
         e.pc   = pc0 + 32'(4 * i);
         e.inst = memf(e.pc);
         sb.push_back(e);
      end
   endtask

   task automatic wait_sb_empty(input string nm);
      int g = 0;
      while (sb.size() != 0 && g < 200) begin
         step();
         g++;
      end
      check(nm, 32'(sb.size()), 32'd0);
   endtask

   // memory: in-order responses lat cycles after each grant
   initial begin
      imem.imem_gnt_i    = 1'b0;
      imem.imem_rvalid_i = 1'b0;
      imem.imem_rdata_i  = 32'h0;
      forever begin
         @(posedge clk);
         #1;
         if (rst) begin
            mcyc++;
            imem.imem_rvalid_i = 1'b0;
            imem.imem_rdata_i  = 32'h0;
            if (mq.size() > 0 && mq[0].due <= mcyc) begin
               imem.imem_rvalid_i = 1'b1;
               imem.imem_rdata_i  = memf(mq[0].addr);
               void'(mq.pop_front());
            end
            imem.imem_gnt_i = 1'b0;
            if (imem.imem_req_o && grants_left > 0) begin
               mreq_t m;
               m.addr = imem.imem_addr_o;
               m.due  = mcyc + lat;
               imem.imem_gnt_i = 1'b1;
               grants_left--;
               granted++;
               mq.push_back(m);
            end
         end
      end
   end

   // monitor: compare every decode pop against the scoreboard
   always @(negedge clk) begin
      ncyc++;
      if (rst) begin
         if (inst_valid_o && !stall && !redirect) begin
            npops++;
            pop_at.push_back(ncyc);
            if (sb.size() == 0) begin
               nchk++;
               nfail++;
               $display("FAIL unexpected_pop: got pc %h inst %h expected none",
                        pc_o, inst_o);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("pop_pc", pc_o, e.pc);
               check("pop_inst", inst_o, e.inst);
            end
         end else if (!inst_valid_o) begin
            check("empty_pc", pc_o, 32'h0);
            check("empty_inst", inst_o, 32'h0);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int g;
      int base;
      int g0;

      // reset state
      #3;
      check("rst_req", 32'(imem.imem_req_o), 32'd0);
      check("rst_valid", 32'(inst_valid_o), 32'd0);
      check("rst_pc", pc_o, 32'h0);
      check("rst_inst", inst_o, 32'h0);
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("idle_no_req", 32'(imem.imem_req_o), 32'd0);
      step();
      check("first_req", 32'(imem.imem_req_o), 32'd1);
      check("first_addr", imem.imem_addr_o, 32'h0);

      // grant withheld: address held, decode empty
      for (int i = 0; i < 4; i++) begin
         step();
         check("hold_req", 32'(imem.imem_req_o), 32'd1);
         check("hold_addr", imem.imem_addr_o, 32'h0);
         check("hold_valid", 32'(inst_valid_o), 32'd0);
         check("hold_inst", inst_o, 32'h0);
      end

      // streaming with 1-cycle memory, then a 5-cycle stall
      lat = 1;
      base = npops;
      push_exp(32'h0, 6);
      grants_left = 6;
      g = 0;
      while (npops - base < 2 && g < 50) begin
         step();
         g++;
      end
      check("p1_pops", 32'(npops - base), 32'd2);
      check("p1_b2b", 32'(pop_at[base+1] - pop_at[base]), 32'd1);
      stall = 1'b1;
      repeat (5) step();
      check("stall_req", 32'(imem.imem_req_o), 32'd0);
      check("stall_valid", 32'(inst_valid_o), 32'd1);
      check("stall_head", pc_o, 32'h8);
      stall = 1'b0;
      wait_sb_empty("p1_drain");
      check("p1_resume_b2b",
            32'(pop_at[base+3] - pop_at[base+2]), 32'd1);

      // 3-cycle memory, two in flight, redirect to 0x103
      lat = 3;
      g0 = granted;
      grants_left = 2;
      g = 0;
      while (granted - g0 < 2 && g < 50) begin
         step();
         g++;
      end
      check("p2_granted", 32'(granted - g0), 32'd2);
      redirect    = 1'b1;
      redirect_pc = 32'h103;
      sb.delete();
      grants_left = 0;
      step();
      redirect = 1'b0;
      g = 0;
      while (!imem.imem_req_o && g < 30) begin
         step();
         g++;
      end
      check("p2_req", 32'(imem.imem_req_o), 32'd1);
      check("p2_addr", imem.imem_addr_o, 32'h100);
      push_exp(32'h100, 2);
      grants_left = 2;
      wait_sb_empty("p2_drain");
`ifdef IF_PERF_EN
      check("p2_dropped", perf_d, 32'd2);
      check("p2_fetched", perf_f, 32'd8);
`endif

      // redirect landing on a cycle with both gnt and rvalid
      lat = 1;
      push_exp(32'h108, 8);
      grants_left = 8;
      g = 0;
      while (!(imem.imem_gnt_i && imem.imem_rvalid_i) && g < 30) begin
         step();
         g++;
      end
      check("p3_overlap", 32'(imem.imem_gnt_i & imem.imem_rvalid_i), 32'd1);
      redirect    = 1'b1;
      redirect_pc = 32'h200;
      sb.delete();
      grants_left = 0;
      step();
      redirect = 1'b0;
      push_exp(32'h200, 2);
      grants_left = 2;
      wait_sb_empty("p3_drain");
`ifdef IF_PERF_EN
      check("p3_dropped", perf_d, 32'd3);
`endif

      // asynchronous reset mid-stream
      push_exp(32'h208, 10);
      grants_left = 10;
      base = npops;
      g = 0;
      while (npops - base < 3 && g < 50) begin
         step();
         g++;
      end
      check("p4_pops", 32'(npops - base), 32'd3);
      #1;
      rst = 1'b0;
      sb.delete();
      mq.delete();
      grants_left = 0;
      imem.imem_gnt_i    = 1'b0;
      imem.imem_rvalid_i = 1'b0;
      #1;
      check("arst_req", 32'(imem.imem_req_o), 32'd0);
      check("arst_valid", 32'(inst_valid_o), 32'd0);
      check("arst_pc", pc_o, 32'h0);
      check("arst_inst", inst_o, 32'h0);
      #3;
      rst = 1'b1;
      #1;
      check("rel_idle", 32'(imem.imem_req_o), 32'd0);
      step();
      check("rel_req", 32'(imem.imem_req_o), 32'd1);
      check("rel_addr", imem.imem_addr_o, 32'h0);
      push_exp(32'h0, 2);
      grants_left = 2;
      wait_sb_empty("p4_drain");
`ifdef IF_PERF_EN
      check("p4_fetched", perf_f, 32'd2);
      check("p4_dropped", perf_d, 32'd0);
`endif
      repeat (3) step();

      $display("End of test - %0d assertions evaluated, %0d failures",
               nchk, nfail);
      $finish;
   end

endmodule
